// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory-port arbiter: FSM state encodings,
// default bus widths and the upper bound of the read-streak counter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // 4-bit saturating streak counter caps the configurable read streak
  localparam int STREAK_W   = 4;
  localparam int STREAK_MAX = 15;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WB_POP   = 3'd1;
  localparam logic [2:0] S_WB_CAP   = 3'd2;
  localparam logic [2:0] S_WB_WRITE = 3'd3;
  localparam logic [2:0] S_RD_ISSUE = 3'd4;
  localparam logic [2:0] S_RD_DONE  = 3'd5;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-state watchdog for mem_port_arbiter (built only with MEM_TIMEOUT_EN).
// Counts cycles spent waiting for mem_ack; o_expired marks the TIMEOUT_CYC-th cycle.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] r_cnt;

  // The wait states are never entered back-to-back, so clearing while idle
  // is the same as clearing on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_run) begin
      r_cnt <= '0;
    end else if (!o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the write-back FIFO and the read-miss path.
// Define MEM_TIMEOUT_EN to add the mem_ack watchdog and the sticky err_timeout output.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_RD_STREAK = 4,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_empty,
  input  logic              wb_full,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              wb_pop,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic              busy
);

  localparam int RD_STREAK_LIM = (MAX_RD_STREAK > STREAK_MAX) ? STREAK_MAX :
                                 (MAX_RD_STREAK < 1) ? 1 : MAX_RD_STREAK;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [STREAK_W-1:0] r_streak;
  logic                r_wb_pop, r_rd_valid, r_mem_req, r_mem_we, r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata, r_rd_data;
  logic                w_wb_grant, w_rd_grant, w_wait, w_timeout;

  assign w_wait = (r_state == S_WB_WRITE) || (r_state == S_RD_ISSUE);

`ifdef MEM_TIMEOUT_EN
  logic r_err_timeout;

  mem_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_run    (w_wait),
    .o_expired(w_timeout)
  );

  // A late mem_ack arriving on the expiry cycle still completes normally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout && !mem_ack) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_wb_grant   = 1'b0;
    w_rd_grant   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_full) begin
          w_wb_grant = 1'b1;
        end else if (rd_req && ((r_streak < STREAK_W'(RD_STREAK_LIM)) || wb_empty)) begin
          w_rd_grant = 1'b1;
        end else if (!wb_empty) begin
          w_wb_grant = 1'b1;
        end
        if (w_wb_grant) begin
          w_state_next = S_WB_POP;
        end else if (w_rd_grant) begin
          w_state_next = S_RD_ISSUE;
        end
      end
      S_WB_POP:   w_state_next = S_WB_CAP;
      S_WB_CAP:   w_state_next = S_WB_WRITE;
      S_WB_WRITE: if (mem_ack || w_timeout) w_state_next = S_IDLE;
      S_RD_ISSUE: if (mem_ack || w_timeout) w_state_next = S_RD_DONE;
      S_RD_DONE:  w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_wb_pop    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_wb_pop   <= w_wb_grant;
      r_rd_valid <= (r_state == S_RD_ISSUE) && (w_state_next == S_RD_DONE);

      if (r_state == S_IDLE) begin
        if (w_wb_grant || wb_empty) begin
          r_streak <= '0;
        end else if (w_rd_grant && (r_streak != STREAK_W'(STREAK_MAX))) begin
          r_streak <= r_streak + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_rd_grant) begin
            r_mem_addr <= rd_addr;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b1;
          end
        end
        // FIFO output is registered: head entry is valid one cycle after the pop
        S_WB_CAP: begin
          r_mem_addr  <= wb_addr;
          r_mem_wdata <= wb_data;
          r_mem_we    <= 1'b1;
          r_mem_req   <= 1'b1;
        end
        S_WB_WRITE: begin
          if (mem_ack || w_timeout) begin
            r_mem_req <= 1'b0;
          end
        end
        S_RD_ISSUE: begin
          if (mem_ack) begin
            r_rd_data <= mem_rdata;
            r_mem_req <= 1'b0;
          end else if (w_timeout) begin
            r_rd_data <= '0;
            r_mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_pop    = r_wb_pop;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: FIFO, memory and read-requester models
// drive the DUT; expected memory transactions and read returns are queued in order.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk, rst_n;
  logic          wb_empty, wb_full, wb_pop;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic          rd_req, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;
`ifdef MEM_TIMEOUT_EN
  logic          err_timeout;
`endif

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_RD_STREAK(4), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_empty(wb_empty), .wb_full(wb_full), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_pop(wb_pop), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef MEM_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  txn_t exp_txn_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [AW+DW-1:0] fifo_q[$];
  int   rd_left = 0;
  int   mem_lat = 2;
  int   lat_cnt = 0;
  bit   ack_en  = 1'b1;
  bit   pop_pend = 1'b0;
  int   pop_cnt = 0;
  int   busy_run = 0, last_busy_len = 0;
  int   req_run = 0, last_req_len = 0;
  bit   prev_req = 1'b0, prev_ack = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rdata_map(input logic [AW-1:0] a);
    if (a == 32'h200) return 32'h1234_5678;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_txn_q.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic exp_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_txn_q.push_back('{we: 1'b0, addr: a, data: '0});
    exp_rd_q.push_back(d);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((busy || exp_txn_q.size() != 0 || exp_rd_q.size() != 0 || rd_left != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("idle_wait_expired", (cyc >= 2000), 1'b0);
    exp_txn_q.delete();
    exp_rd_q.delete();
    step(2);
  endtask

  // Input driver: FIFO, memory responder and read requester, all just after posedge
  initial begin
    wb_empty = 1'b1; wb_full = 1'b0; wb_addr = '0; wb_data = '0;
    rd_req = 1'b0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        fifo_q.delete();
        lat_cnt = 0;
      end else begin
        if (pop_pend && fifo_q.size() != 0) begin
          {wb_addr, wb_data} = fifo_q.pop_front();
        end
        if (mem_req && ack_en) begin
          if (lat_cnt == mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata_map(mem_addr);
            lat_cnt   = 0;
          end else begin
            lat_cnt++;
          end
        end
        if (rd_valid && rd_left > 0) begin
          rd_left--;
          rd_addr = rd_addr + 32'd4;
        end
      end
      wb_empty = (fifo_q.size() == 0);
      wb_full  = (fifo_q.size() >= FIFO_DEPTH);
      rd_req   = rst_n && (rd_left > 0);
    end
  end

  // Output monitor and scoreboard, sampled on the falling edge
  initial begin
    txn_t t;
    logic [DW-1:0] r;
    forever begin
      @(negedge clk);
      pop_pend = wb_pop && rst_n;
      if (!rst_n) begin
        prev_req = 1'b0; prev_ack = 1'b0; busy_run = 0; req_run = 0;
      end else begin
        if (wb_pop) begin
          pop_cnt++;
          check_val("pop_while_empty", wb_empty, 1'b0);
        end
        if (mem_req && !prev_req) begin
          $display("mem txn: we=%0d addr=0x%08h wdata=0x%08h", mem_we, mem_addr, mem_wdata);
          if (exp_txn_q.size() == 0) begin
            check_val("txn_unexpected", 1'b1, 1'b0);
          end else begin
            t = exp_txn_q.pop_front();
            check_val("txn_we", mem_we, t.we);
            check_val("txn_addr", mem_addr, t.addr);
            if (t.we) check_val("txn_wdata", mem_wdata, t.data);
          end
        end
        if (rd_valid) begin
          $display("rd return: data=0x%08h", rd_data);
          if (exp_rd_q.size() == 0) begin
            check_val("rd_unexpected", 1'b1, 1'b0);
          end else begin
            r = exp_rd_q.pop_front();
            check_val("rd_data", rd_data, r);
          end
          if (ack_en) check_val("rd_valid_after_ack", prev_ack, 1'b1);
        end
        if (busy) busy_run++;
        else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end
        if (mem_req) req_run++;
        else if (req_run != 0) begin last_req_len = req_run; req_run = 0; end
        prev_req = mem_req;
        prev_ack = mem_ack;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pops_before;
    rst_n = 1'b0;
    step(3);
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wb_pop", wb_pop, 1'b0);
    check_val("rst_rd_valid", rd_valid, 1'b0);
    check_val("rst_mem_we", mem_we, 1'b0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_rd_data", rd_data, 32'h0);
`ifdef MEM_TIMEOUT_EN
    check_val("rst_err_timeout", err_timeout, 1'b0);
`endif
    rst_n = 1'b1;
    step(2);

    // single write
    pops_before = pop_cnt;
    fifo_q.push_back({32'h100, 32'hDEAD_BEEF});
    exp_wr(32'h100, 32'hDEAD_BEEF);
    wait_idle();
    check_val("write_busy_cycles", last_busy_len, 5);
    check_val("write_pop_count", pop_cnt - pops_before, 1);

    // single read
    exp_rd(32'h200, 32'h1234_5678);
    rd_addr = 32'h200;
    rd_left = 1;
    wait_idle();

    // starvation bound: 4 reads, write, 4 reads, write, remaining reads
    fifo_q.push_back({32'hA00, 32'hAAAA_0001});
    fifo_q.push_back({32'hB00, 32'hBBBB_0002});
    for (int i = 0; i < 10; i++) begin
      if (i == 4) exp_wr(32'hA00, 32'hAAAA_0001);
      if (i == 8) exp_wr(32'hB00, 32'hBBBB_0002);
      exp_rd(32'h300 + 32'(4 * i), rdata_map(32'h300 + 32'(4 * i)));
    end
    rd_addr = 32'h300;
    rd_left = 10;
    wait_idle();

    // full FIFO beats a pending read; once not full, the read goes next
    for (int i = 0; i < FIFO_DEPTH; i++) fifo_q.push_back({32'hC00 + 32'(i), 32'hC0DE_0000 + 32'(i)});
    exp_wr(32'hC00, 32'hC0DE_0000);
    exp_rd(32'h400, rdata_map(32'h400));
    for (int i = 1; i < FIFO_DEPTH; i++) exp_wr(32'hC00 + 32'(i), 32'hC0DE_0000 + 32'(i));
    rd_addr = 32'h400;
    rd_left = 1;
    wait_idle();

    // empty FIFO: unlimited reads, and the streak is left at zero afterwards
    for (int i = 0; i < 6; i++) exp_rd(32'h600 + 32'(4 * i), rdata_map(32'h600 + 32'(4 * i)));
    rd_addr = 32'h600;
    rd_left = 6;
    wait_idle();
    fifo_q.push_back({32'hD00, 32'hD00D_0001});
    for (int i = 0; i < 5; i++) begin
      if (i == 4) exp_wr(32'hD00, 32'hD00D_0001);
      exp_rd(32'h700 + 32'(4 * i), rdata_map(32'h700 + 32'(4 * i)));
    end
    rd_addr = 32'h700;
    rd_left = 5;
    wait_idle();

    // reset in the middle of a write
    ack_en = 1'b0;
    fifo_q.push_back({32'hE00, 32'hE00E_0001});
    exp_wr(32'hE00, 32'hE00E_0001);
    for (int i = 0; i < 50 && !mem_req; i++) step(1);
    check_val("mid_op_req_seen", mem_req, 1'b1);
    step(1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_mem_req", mem_req, 1'b0);
    check_val("async_rst_busy", busy, 1'b0);
    step(2);
    pops_before = pop_cnt;
    rst_n = 1'b1;
    ack_en = 1'b1;
    step(6);
    check_val("post_rst_pop_count", pop_cnt - pops_before, 0);
    check_val("post_rst_busy", busy, 1'b0);
    check_val("post_rst_mem_req", mem_req, 1'b0);
    exp_txn_q.delete();

`ifdef MEM_TIMEOUT_EN
    // read with no mem_ack: times out, returns zero, sets sticky error
    check_val("err_before_timeout", err_timeout, 1'b0);
    ack_en = 1'b0;
    exp_rd(32'h500, 32'h0);
    rd_addr = 32'h500;
    rd_left = 1;
    wait_idle();
    check_val("timeout_req_cycles", last_req_len, 10);
    check_val("err_after_timeout", err_timeout, 1'b1);
    ack_en = 1'b1;
    fifo_q.push_back({32'hF00, 32'hF00F_0001});
    exp_wr(32'hF00, 32'hF00F_0001);
    wait_idle();
    check_val("err_sticky", err_timeout, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-clock scheduler that shares the one main-memory port between two requesters.
- Requester 1 is the cache-to-main write-back FIFO; the arbiter pops it and issues memory writes.
- Requester 2 is the cache read-miss path; the arbiter issues memory reads and returns the data.
- Sits between the cache write-back FIFO / miss logic and the main-memory interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_RD_STREAK, 4, maximum consecutive read grants while the FIFO is non-empty; 1..15.
- TIMEOUT_CYC, 255, watchdog limit in cycles; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_empty  in  1  write-back FIFO empty.
- wb_full  in  1  write-back FIFO full.
- wb_data  in  DATA_W  FIFO read data; registered, valid the cycle after wb_pop.
- wb_addr  in  ADDR_W  FIFO read address; same timing as wb_data.
- wb_pop  out  1  one-cycle pop strobe to the FIFO.
- rd_req  in  1  read-miss request, level; held with rd_addr stable until rd_valid.
- rd_addr  in  ADDR_W  read-miss address.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  DATA_W  read return data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs registered and cleared to 0; state = IDLE; streak counter = 0.
- Reset mid-transaction aborts immediately with no retry; the memory and FIFO are reset by the same rst_n.
- FSM states:
  - IDLE, WB_POP, WB_CAP, WB_WRITE, RD_ISSUE, RD_DONE.
- IDLE arbitration, evaluated in priority order:
  1. wb_full -> WB_POP.
  2. rd_req && (streak < MAX_RD_STREAK || wb_empty) -> RD_ISSUE.
  3. !wb_empty -> WB_POP.
  4. Otherwise stay in IDLE.
- Write path:
  - WB_POP: wb_pop = 1 for exactly one cycle; next state WB_CAP.
  - WB_CAP: latch wb_addr/wb_data into mem_addr/mem_wdata; set mem_req = 1, mem_we = 1; next state WB_WRITE.
  - WB_WRITE: hold all memory outputs until mem_ack.
  - On mem_ack: mem_req drops the next cycle; return to IDLE; streak := 0.
  - Minimum write occupancy is 3 cycles plus memory latency.
- Read path:
  - Entering RD_ISSUE: mem_addr := rd_addr, mem_we = 0, mem_req = 1.
  - On mem_ack: capture mem_rdata into rd_data; go to RD_DONE.
  - RD_DONE: rd_valid = 1 for one cycle; then IDLE.
  - The requester must drop rd_req no later than the cycle after rd_valid.
- Streak counter (4 bits, saturating):
  - +1 on each read grant made while wb_empty = 0.
  - Cleared on a write grant, or whenever wb_empty = 1 in IDLE.
- mem_ack outside WB_WRITE/RD_ISSUE is ignored.
- wb_pop is never asserted while wb_empty = 1.
- At most one outstanding memory transaction; no pipelining.
- Read-after-write ordering to the same address is the cache's responsibility; this block does no address compare.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter runs in WB_WRITE/RD_ISSUE; it is cleared on state entry.
  - When it reaches TIMEOUT_CYC: drop mem_req, go to IDLE, and set output err_timeout (sticky, 1 bit, cleared only by rst_n).
  - A timed-out read still pulses rd_valid with rd_data = 0.
- When undefined:
  - No counter and no err_timeout port; the block waits for mem_ack indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum localparams;
  - the default ADDR_W/DATA_W;
  - the MAX_RD_STREAK bound.
- One natural sub-module, mem_arb_watchdog: the timeout counter, instantiated only under MEM_TIMEOUT_EN.
- All other logic stays in one module.

Test Plan:
- Single write:
  - Stimulus: wb_empty = 0, head {addr 0x100, data 0xDEADBEEF}, mem_ack 2 cycles after mem_req.
  - Response: one wb_pop pulse; mem_we = 1, addr 0x100, wdata 0xDEADBEEF; busy for 5 cycles; back to IDLE.
- Single read:
  - Stimulus: rd_req with rd_addr 0x200; mem_ack with mem_rdata 0x12345678.
  - Response: mem_we = 0, addr 0x200; rd_valid pulse one cycle after ack; rd_data = 0x12345678.
- Starvation bound:
  - Stimulus: rd_req held continuously, FIFO holds 2 entries, MAX_RD_STREAK = 4.
  - Response: exactly 4 reads, then 1 write, then reads resume.
- Full priority:
  - Stimulus: rd_req and wb_full both high in IDLE.
  - Response: write granted first.
  - With wb_empty = 1: reads unlimited and streak stays 0.
- Reset mid-op:
  - Stimulus: rst_n low during WB_WRITE.
  - Response: mem_req/busy low asynchronously; after release, IDLE with no spurious wb_pop.
- MEM_TIMEOUT_EN, TIMEOUT_CYC = 10:
  - Stimulus: no mem_ack on a read.
  - Response: mem_req drops after 10 cycles; err_timeout = 1 (sticky); rd_valid pulse with rd_data = 0.
